bilinear_interp: RTL and testbench

//  Stage directly downstream of the rotation point calculator. Takes one centred source coordinate
//  (integer x/y plus 10-bit fractional weights fx/fy) per request and fetches the 4 neighbour pixels

---
 rtl/rot_pkg.sv | 27 ++
 rtl/bilinear_mac.sv | 47 ++++
 rtl/bilinear_interp.sv | 168 ++++++++++++++++
 tb/tb_bilinear_interp.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotation pipeline: fixed-point widths, FSM encodings
// and the return-slot tag carried alongside frame-memory reads.
package rot_pkg;
    localparam int FRAC_BITS = 10;
    localparam int ONE       = 1024;
    localparam int PIX_W     = 8;
    localparam int COORD_W   = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_CALC,
        ST_OUT
    } state_t;

    typedef struct packed {
        logic       vld;
        logic       en;
        logic [1:0] idx;
    } slot_tag_t;

    // Signed 13-bit coordinate lies in [0, lim).
    function automatic logic in_range(input logic [COORD_W:0] v, input logic [COORD_W-1:0] lim);
        return !v[COORD_W] && (v[COORD_W-1:0] < lim);
    endfunction
endpackage

// File: rtl/bilinear_mac.sv
// Weighted sum of four neighbour pixels with round-to-nearest and saturation.
// One register stage; pixel loads only when en is high and otherwise holds.
module bilinear_mac
    import rot_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [PIX_W-1:0]     p00,
    input  logic [PIX_W-1:0]     p01,
    input  logic [PIX_W-1:0]     p10,
    input  logic [PIX_W-1:0]     p11,
    input  logic [FRAC_BITS:0]   fx,
    input  logic [FRAC_BITS:0]   fy,
    output logic [PIX_W-1:0]     pixel
);
    logic [FRAC_BITS:0] gx, gy;
    logic [21:0]        w00, w01, w10, w11;
    logic [29:0]        m00, m01, m10, m11;
    logic [28:0]        sum;
    logic [9:0]         q;
    logic [PIX_W-1:0]   pixel_d;

    always_comb begin
        gx  = 11'(ONE) - fx;
        gy  = 11'(ONE) - fy;
        w00 = 22'(gx) * 22'(gy);
        w01 = 22'(fx) * 22'(gy);
        w10 = 22'(gx) * 22'(fy);
        w11 = 22'(fx) * 22'(fy);
        m00 = 30'(w00) * 30'(p00);
        m01 = 30'(w01) * 30'(p01);
        m10 = 30'(w10) * 30'(p10);
        m11 = 30'(w11) * 30'(p11);
        sum = 29'(m00 + m01 + m10 + m11);
        // Add half an LSB of the 20-bit fraction, then drop it.
        q       = 10'(({1'b0, sum} + 30'd524288) >> 20);
        pixel_d = (q > 10'd255) ? 8'hFF : q[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pixel <= '0;
        else if (en)
            pixel <= pixel_d;
    end
endmodule

// File: rtl/bilinear_interp.sv
// Fetches four neighbours of a centred coordinate and emits one bilinear pixel.
// Latency accept->o_valid is 6+RD_LAT; one request in flight, extra requests dropped and flagged.
module bilinear_interp
    import rot_pkg::*;
#(
    parameter int          RD_LAT   = 2,
    parameter int          ADDR_W   = 24,
    parameter logic [7:0]  BG_PIXEL = 8'd0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_fsyn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [11:0]       iv_p1x,
    input  logic [11:0]       iv_p2y,
    input  logic [10:0]       iv_fx,
    input  logic [10:0]       iv_fy,
    input  logic [11:0]       iv_width,
    input  logic [11:0]       iv_depth,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] ov_rd_addr,
    input  logic [7:0]        iv_rd_data,
    output logic              o_valid,
    output logic [7:0]        ov_pixel,
    output logic              o_overflow
);
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_t            state;
    logic [1:0]        fetch_idx;
    logic [1:0]        wait_cnt;
    logic [11:0]       c0_q, r0_q, width_q;
    logic [3:0]        mask_q;
    logic [10:0]       fx_q, fy_q;
    logic [7:0]        slot [4];
    slot_tag_t         tag_pipe [RD_LAT];

    logic [12:0]       in_c0, in_c1, in_r0, in_r1;
    logic [3:0]        in_mask;
    logic              accept;
    logic [1:0]        nxt_idx;
    logic [11:0]       row, col, w_sel;
    logic              nxt_en;
    logic [ADDR_W-1:0] nxt_addr;

    always_comb begin
        in_c0   = {iv_p1x[11], iv_p1x} + {2'b00, iv_width[11:1]};
        in_c1   = in_c0 + 13'd1;
        in_r0   = {2'b00, iv_depth[11:1]} - ({iv_p2y[11], iv_p2y} + 13'd1);
        in_r1   = in_r0 + 13'd1;
        in_mask = {in_range(in_c1, iv_width) && in_range(in_r1, iv_depth),
                   in_range(in_c0, iv_width) && in_range(in_r1, iv_depth),
                   in_range(in_c1, iv_width) && in_range(in_r0, iv_depth),
                   in_range(in_c0, iv_width) && in_range(in_r0, iv_depth)};

        // The first address comes straight from the request; later ones from the latched copy.
        accept   = o_ready && i_valid && !i_fsyn;
        nxt_idx  = accept ? 2'd0 : fetch_idx + 2'd1;
        row      = (accept ? in_r0[11:0] : r0_q) + {11'd0, nxt_idx[1]};
        col      = (accept ? in_c0[11:0] : c0_q) + {11'd0, nxt_idx[0]};
        w_sel    = accept ? iv_width : width_q;
        nxt_en   = accept ? in_mask[0] : mask_q[nxt_idx];
        nxt_addr = ADDR_W'(row) * ADDR_W'(w_sel) + ADDR_W'(col);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            o_ready    <= 1'b1;
            o_rd_en    <= 1'b0;
            ov_rd_addr <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
            fetch_idx  <= '0;
            wait_cnt   <= '0;
            c0_q       <= '0;
            r0_q       <= '0;
            width_q    <= '0;
            mask_q     <= '0;
            fx_q       <= '0;
            fy_q       <= '0;
        end else if (i_fsyn) begin
            state      <= ST_IDLE;
            o_ready    <= 1'b1;
            o_rd_en    <= 1'b0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_valid && !o_ready)
                o_overflow <= 1'b1;
            case (state)
                ST_IDLE: if (i_valid) begin
                    c0_q      <= in_c0[11:0];
                    r0_q      <= in_r0[11:0];
                    width_q   <= iv_width;
                    mask_q    <= in_mask;
                    fx_q      <= iv_fx;
                    fy_q      <= iv_fy;
                    fetch_idx <= 2'd0;
                    o_ready   <= 1'b0;
                    o_rd_en   <= nxt_en;
                    if (nxt_en)
                        ov_rd_addr <= nxt_addr;
                    state     <= ST_FETCH;
                end
                ST_FETCH: if (fetch_idx == 2'd3) begin
                    o_rd_en  <= 1'b0;
                    wait_cnt <= 2'd0;
                    state    <= ST_WAIT;
                end else begin
                    fetch_idx <= nxt_idx;
                    o_rd_en   <= nxt_en;
                    if (nxt_en)
                        ov_rd_addr <= nxt_addr;
                end
                ST_WAIT: if (wait_cnt == WAIT_LAST)
                    state <= ST_CALC;
                else
                    wait_cnt <= wait_cnt + 2'd1;
                ST_CALC: begin
                    o_valid <= 1'b1;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    o_ready <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Slot tags trail each issue slot by RD_LAT cycles to line up with returned data.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || i_fsyn) begin
            for (int i = 0; i < RD_LAT; i++)
                tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= {state == ST_FETCH, o_rd_en, fetch_idx};
            for (int i = 1; i < RD_LAT; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++)
                slot[i] <= '0;
        end else if (!i_fsyn && tag_pipe[RD_LAT-1].vld) begin
            slot[tag_pipe[RD_LAT-1].idx] <= tag_pipe[RD_LAT-1].en ? iv_rd_data : BG_PIXEL;
        end
    end

    bilinear_mac u_mac (
        .clk   (i_clk),
        .reset (i_reset),
        .en    ((state == ST_CALC) && !i_fsyn),
        .p00   (slot[0]),
        .p01   (slot[1]),
        .p10   (slot[2]),
        .p11   (slot[3]),
        .fx    (fx_q),
        .fy    (fy_q),
        .pixel (ov_pixel)
    );
endmodule

// File: tb/tb_bilinear_interp.sv
// Directed bench for bilinear_interp with RD_LAT=2 and a delayed-read frame-memory model.
module tb_bilinear_interp;
    logic        clk = 1'b0;
    logic        rst, fsyn, vin, rdy, rd_en, vout, ovf;
    logic [11:0] p1x, p2y, width, depth;
    logic [10:0] fx, fy;
    logic [23:0] rd_addr;
    logic [7:0]  rd_data, pixel;

    logic [7:0]  mem [256];
    logic [23:0] a_d [2];
    logic        e_d [2];
    logic [23:0] rd_log [$];

    int checks = 0;
    int fails  = 0;
    int lat;
    logic [7:0] pix;
    int nvalid, first_v, second_v;

    always #5 clk = ~clk;

    bilinear_interp #(.RD_LAT(2), .ADDR_W(24), .BG_PIXEL(8'd0)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_fsyn     (fsyn),
        .i_valid    (vin),
        .o_ready    (rdy),
        .iv_p1x     (p1x),
        .iv_p2y     (p2y),
        .iv_fx      (fx),
        .iv_fy      (fy),
        .iv_width   (width),
        .iv_depth   (depth),
        .o_rd_en    (rd_en),
        .ov_rd_addr (rd_addr),
        .iv_rd_data (rd_data),
        .o_valid    (vout),
        .ov_pixel   (pixel),
        .o_overflow (ovf)
    );

    // Two-cycle read pipe; unread cycles return a junk value so BG substitution is visible.
    always @(posedge clk) begin
        a_d[0] <= rd_addr;
        e_d[0] <= rd_en;
        a_d[1] <= a_d[0];
        e_d[1] <= e_d[0];
    end
    assign rd_data = (e_d[1] === 1'b1) ? mem[a_d[1][7:0]] : 8'hA5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] log_at(input int i);
        return (rd_log.size() > i) ? rd_log[i] : 24'hFFFFFF;
    endfunction

    task automatic do_req(input logic [11:0] x, input logic [11:0] y,
                          input logic [10:0] a, input logic [10:0] b,
                          output int l, output logic [7:0] p);
        @(negedge clk);
        p1x = x; p2y = y; fx = a; fy = b; vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
        rd_log.delete();
        l = -1;
        p = 8'h00;
        for (int c = 1; c < 40; c++) begin
            if (rd_en) rd_log.push_back(rd_addr);
            if (vout) begin
                l = c;
                p = pixel;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; fsyn = 1'b0; vin = 1'b0;
        p1x = '0; p2y = '0; fx = '0; fy = '0;
        width = 12'd8; depth = 12'd8;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy), 32'd1);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_valid", 32'(vout), 32'd0);
        chk("rst_pixel", 32'(pixel), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // 1: centre point, all weight on P00
        do_req(12'd0, 12'hFFF, 11'd0, 11'd0, lat, pix);
        chk("t1_lat", 32'(lat), 32'd8);
        chk("t1_pix", 32'(pix), 32'd36);
        chk("t1_nrd", 32'(rd_log.size()), 32'd4);
        chk("t1_a0", 32'(log_at(0)), 32'd36);
        chk("t1_a1", 32'(log_at(1)), 32'd37);
        chk("t1_a2", 32'(log_at(2)), 32'd44);
        chk("t1_a3", 32'(log_at(3)), 32'd45);

        // 2: equal weights, (36+37+44+45)/4 = 40.5 rounds to 41
        do_req(12'd0, 12'hFFF, 11'd512, 11'd512, lat, pix);
        chk("t2_lat", 32'(lat), 32'd8);
        chk("t2_pix", 32'(pix), 32'd41);

        // 3: right column is off the frame, both P01 and P11 become BG
        do_req(12'd3, 12'hFFF, 11'd512, 11'd0, lat, pix);
        chk("t3_pix", 32'(pix), 32'd20);
        chk("t3_nrd", 32'(rd_log.size()), 32'd2);
        chk("t3_a0", 32'(log_at(0)), 32'd39);
        chk("t3_a1", 32'(log_at(1)), 32'd47);
        repeat (3) @(negedge clk);
        chk("t3_hold", 32'(pixel), 32'd20);

        // full weight on P01
        do_req(12'd0, 12'hFFF, 11'd1024, 11'd0, lat, pix);
        chk("fx1024_pix", 32'(pix), 32'd37);

        // 4: i_valid held for 20 cycles -> accepts at cycles 0, 9, 18
        @(negedge clk);
        p1x = 12'd0; p2y = 12'hFFF; fx = 11'd512; fy = 11'd512; vin = 1'b1;
        nvalid = 0; first_v = -1; second_v = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 20) vin = 1'b0;
            if (vout) begin
                nvalid++;
                if (nvalid == 1) first_v = c;
                if (nvalid == 2) second_v = c;
                chk("t4_pix", 32'(pixel), 32'd41);
            end
        end
        chk("t4_count", 32'(nvalid), 32'd3);
        chk("t4_first", 32'(first_v), 32'd8);
        chk("t4_gap", 32'(second_v - first_v), 32'd9);
        chk("t4_ovf", 32'(ovf), 32'd1);

        // 5: frame sync (with a same-cycle request) during WAIT aborts the request
        @(negedge clk);
        p1x = 12'd0; p2y = 12'hFFF; fx = 11'd0; fy = 11'd0; vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
        repeat (4) @(negedge clk);
        fsyn = 1'b1; vin = 1'b1;
        @(negedge clk);
        fsyn = 1'b0; vin = 1'b0;
        chk("t5_ready", 32'(rdy), 32'd1);
        chk("t5_ovf", 32'(ovf), 32'd0);
        chk("t5_rd_en", 32'(rd_en), 32'd0);
        nvalid = 0;
        for (int c = 0; c < 15; c++) begin
            if (vout) nvalid++;
            @(negedge clk);
        end
        chk("t5_novalid", 32'(nvalid), 32'd0);
        do_req(12'd0, 12'hFFF, 11'd512, 11'd512, lat, pix);
        chk("t5_next_lat", 32'(lat), 32'd8);
        chk("t5_next_pix", 32'(pix), 32'd41);

        // 6: saturation corner, all weight on P11 = 255
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        do_req(12'd0, 12'hFFF, 11'd1024, 11'd1024, lat, pix);
        chk("t6_pix", 32'(pix), 32'd255);

        // async reset in the middle of FETCH, after an overflow has been flagged
        @(negedge clk);
        p1x = 12'd0; p2y = 12'hFFF; fx = 11'd512; fy = 11'd512; vin = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vin = 1'b0;
        chk("rs_pre_ovf", 32'(ovf), 32'd1);
        chk("rs_pre_rd_en", 32'(rd_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rs_ready", 32'(rdy), 32'd1);
        chk("rs_rd_en", 32'(rd_en), 32'd0);
        chk("rs_addr", 32'(rd_addr), 32'd0);
        chk("rs_valid", 32'(vout), 32'd0);
        chk("rs_pixel", 32'(pixel), 32'd0);
        chk("rs_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (vout) nvalid++;
        end
        chk("rs_novalid", 32'(nvalid), 32'd0);
        chk("rs_idle_ready", 32'(rdy), 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
